// File: rtl/agc_pkg.sv
// Shared types and constants for the AGC one's-complement datapath.
package agc_pkg;

  localparam int unsigned AGC_WORD_W = 15;

  typedef enum logic [1:0] {
    OP_COM = 2'd0,
    OP_CMP = 2'd1,
    OP_ADD = 2'd2,
    OP_SUB = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC  = 2'd1,
    CARRY = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/ones_comp_cmp.sv
// Combinational signed one's-complement compare; +0 and -0 compare equal.
module ones_comp_cmp #(
  parameter int unsigned WIDTH = 15
) (
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] y_i,
  output logic             gt_o,
  output logic             eq_o,
  output logic             lt_o
);

  logic [WIDTH:0]        x_mag, y_mag;
  logic signed [WIDTH:0] x_val, y_val;

  // Map each word to its two's-complement value; -0 (all ones) becomes 0.
  always_comb begin
    x_mag = {1'b0, (x_i[WIDTH-1] ? ~x_i : x_i)};
    y_mag = {1'b0, (y_i[WIDTH-1] ? ~y_i : y_i)};
    x_val = x_i[WIDTH-1] ? -$signed(x_mag) : $signed(x_mag);
    y_val = y_i[WIDTH-1] ? -$signed(y_mag) : $signed(y_mag);
    gt_o  = (x_val > y_val);
    eq_o  = (x_val == y_val);
    lt_o  = (x_val < y_val);
  end

endmodule

// File: rtl/ones_comp_unit.sv
// One's-complement COM/CMP/ADD/SUB unit with valid/ready handshake and
// a two-step end-around-carry adder.
module ones_comp_unit
  import agc_pkg::*;
#(
  parameter int unsigned WIDTH = AGC_WORD_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             gt,
  output logic             eq,
  output logic             lt,
  output logic             ovf
);

  state_e           state_q;
  op_e              op_q;
  logic [WIDTH-1:0] a_q, b_q, sum_q, result_q;
  logic             carry_q, gt_q, eq_q, lt_q, ovf_q, out_valid_q;

  logic [WIDTH-1:0] b_eff, fin, zx;
  logic [WIDTH:0]   raw;
  logic             ovf_c;
  logic             ab_gt, ab_eq, ab_lt, z_gt, z_eq, z_lt;

  always_comb begin
    b_eff = (op_q == OP_SUB) ? ~b_q : b_q;
    raw   = {1'b0, a_q} + {1'b0, b_eff};
    // The end-around add of a registered carry can never carry again.
    fin   = sum_q + {{(WIDTH-1){1'b0}}, carry_q};
    zx    = (state_q == CARRY) ? fin : ~a_q;
    ovf_c = (a_q[WIDTH-1] == b_eff[WIDTH-1]) && (fin[WIDTH-1] != a_q[WIDTH-1]);
  end

  ones_comp_cmp #(.WIDTH(WIDTH)) u_cmp_ab (
    .x_i  (a_q),
    .y_i  (b_q),
    .gt_o (ab_gt),
    .eq_o (ab_eq),
    .lt_o (ab_lt)
  );

  ones_comp_cmp #(.WIDTH(WIDTH)) u_cmp_zero (
    .x_i  (zx),
    .y_i  ({WIDTH{1'b0}}),
    .gt_o (z_gt),
    .eq_o (z_eq),
    .lt_o (z_lt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      op_q        <= OP_COM;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      result_q    <= '0;
      gt_q        <= 1'b0;
      eq_q        <= 1'b0;
      lt_q        <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            op_q    <= op_e'(op);
            a_q     <= a;
            b_q     <= b;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          if (op_q == OP_COM || op_q == OP_CMP) begin
            result_q    <= (op_q == OP_COM) ? ~a_q : a_q;
            gt_q        <= (op_q == OP_COM) ? z_gt : ab_gt;
            eq_q        <= (op_q == OP_COM) ? z_eq : ab_eq;
            lt_q        <= (op_q == OP_COM) ? z_lt : ab_lt;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            {carry_q, sum_q} <= raw;
            state_q          <= CARRY;
          end
        end
        CARRY: begin
          result_q    <= fin;
          gt_q        <= z_gt;
          eq_q        <= z_eq;
          lt_q        <= z_lt;
          ovf_q       <= ovf_c;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign gt        = gt_q;
  assign eq        = eq_q;
  assign lt        = lt_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_ones_comp_unit.sv
// Directed bench for ones_comp_unit at WIDTH 15, 8 and 16.
module tb_ones_comp_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [1:0]  op_d = 2'd0;
  logic [15:0] a_d = '0, b_d = '0;
  int          sel = 0;
  int          checks = 0;
  int          errors = 0;

  logic        rdy15, rdy8, rdy16, ov15, ov8, ov16;
  logic [14:0] r15;
  logic [7:0]  r8;
  logic [15:0] r16;
  logic [3:0]  f15, f8, f16;  // {gt, eq, lt, ovf}

  logic        rdy_m, ov_m;
  logic [15:0] res_m;
  logic [3:0]  flg_m;

  always #5 clk = ~clk;

  ones_comp_unit #(.WIDTH(15)) u_dut15 (
    .clk(clk), .reset(reset), .in_valid(in_valid && sel == 0), .in_ready(rdy15),
    .op(op_d), .a(a_d[14:0]), .b(b_d[14:0]), .out_valid(ov15), .out_ready(out_ready),
    .result(r15), .gt(f15[3]), .eq(f15[2]), .lt(f15[1]), .ovf(f15[0])
  );

  ones_comp_unit #(.WIDTH(8)) u_dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid && sel == 1), .in_ready(rdy8),
    .op(op_d), .a(a_d[7:0]), .b(b_d[7:0]), .out_valid(ov8), .out_ready(out_ready),
    .result(r8), .gt(f8[3]), .eq(f8[2]), .lt(f8[1]), .ovf(f8[0])
  );

  ones_comp_unit #(.WIDTH(16)) u_dut16 (
    .clk(clk), .reset(reset), .in_valid(in_valid && sel == 2), .in_ready(rdy16),
    .op(op_d), .a(a_d), .b(b_d), .out_valid(ov16), .out_ready(out_ready),
    .result(r16), .gt(f16[3]), .eq(f16[2]), .lt(f16[1]), .ovf(f16[0])
  );

  always_comb begin
    rdy_m = rdy15;
    ov_m  = ov15;
    res_m = {1'b0, r15};
    flg_m = f15;
    if (sel == 1) begin
      rdy_m = rdy8; ov_m = ov8; res_m = {8'h00, r8}; flg_m = f8;
    end else if (sel == 2) begin
      rdy_m = rdy16; ov_m = ov16; res_m = r16; flg_m = f16;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s (width sel %0d): got %h expected %h", tag, sel, got, exp);
    end
  endtask

  typedef struct {
    int          s;
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic [3:0]  flg;  // {gt, eq, lt, ovf}
  } vec_t;

  vec_t vecs[$];

  task automatic run_vec(input vec_t v);
    int lat;
    logic [15:0] hold_res;
    logic [3:0]  hold_flg;
    sel = v.s;
    #1;
    check("in_ready_idle", 32'(rdy_m), 32'd1);
    in_valid = 1'b1; op_d = v.op; a_d = v.a; b_d = v.b;
    @(posedge clk); #1;
    // Scramble inputs after accept; the unit must ignore them.
    in_valid = 1'b0; op_d = ~v.op; a_d = 16'hA5A5; b_d = 16'h5A5A;
    lat = 1;
    while (!ov_m && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 32'(lat), (v.op >= 2'd2) ? 32'd3 : 32'd2);
    check("result", 32'(res_m), 32'(v.res));
    check("flags", 32'(flg_m), 32'(v.flg));
    check("in_ready_busy", 32'(rdy_m), 32'd0);
    if (v.op == 2'd3) begin
      hold_res = res_m;
      hold_flg = flg_m;
      for (int i = 0; i < 5; i++) begin
        @(posedge clk); #1;
        check("hold_valid", 32'(ov_m), 32'd1);
        check("hold_result", 32'(res_m), 32'(hold_res));
        check("hold_flags", 32'(flg_m), 32'(hold_flg));
        check("hold_in_ready", 32'(rdy_m), 32'd0);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("drain_valid", 32'(ov_m), 32'd0);
    check("drain_in_ready", 32'(rdy_m), 32'd1);
  endtask

  initial begin
    // Width 15
    vecs.push_back('{0, 2'd0, 16'h72C2, 16'h0000, 16'h0D3D, 4'b1000});
    vecs.push_back('{0, 2'd0, 16'h0000, 16'h0000, 16'h7FFF, 4'b0100});
    vecs.push_back('{0, 2'd0, 16'h0001, 16'h0000, 16'h7FFE, 4'b0010});
    vecs.push_back('{0, 2'd1, 16'h72C2, 16'h0001, 16'h72C2, 4'b0010});
    vecs.push_back('{0, 2'd1, 16'h0001, 16'h72C2, 16'h0001, 4'b1000});
    vecs.push_back('{0, 2'd1, 16'h0000, 16'h7FFF, 16'h0000, 4'b0100});
    vecs.push_back('{0, 2'd1, 16'h7FFF, 16'h0000, 16'h7FFF, 4'b0100});
    vecs.push_back('{0, 2'd2, 16'h0003, 16'h7FFE, 16'h0002, 4'b1000});
    vecs.push_back('{0, 2'd2, 16'h3FFF, 16'h0001, 16'h4000, 4'b0011});
    vecs.push_back('{0, 2'd3, 16'h0005, 16'h0005, 16'h7FFF, 4'b0100});
    vecs.push_back('{0, 2'd3, 16'h4000, 16'h0001, 16'h3FFF, 4'b1001});
    // Width 8
    vecs.push_back('{1, 2'd0, 16'h00C2, 16'h0000, 16'h003D, 4'b1000});
    vecs.push_back('{1, 2'd1, 16'h00C2, 16'h0001, 16'h00C2, 4'b0010});
    vecs.push_back('{1, 2'd1, 16'h0000, 16'h00FF, 16'h0000, 4'b0100});
    vecs.push_back('{1, 2'd1, 16'h00FF, 16'h0000, 16'h00FF, 4'b0100});
    vecs.push_back('{1, 2'd2, 16'h0003, 16'h00FE, 16'h0002, 4'b1000});
    vecs.push_back('{1, 2'd2, 16'h007F, 16'h0001, 16'h0080, 4'b0011});
    vecs.push_back('{1, 2'd3, 16'h0005, 16'h0005, 16'h00FF, 4'b0100});
    // Width 16
    vecs.push_back('{2, 2'd0, 16'hE5C2, 16'h0000, 16'h1A3D, 4'b1000});
    vecs.push_back('{2, 2'd1, 16'hE5C2, 16'h0001, 16'hE5C2, 4'b0010});
    vecs.push_back('{2, 2'd1, 16'h0000, 16'hFFFF, 16'h0000, 4'b0100});
    vecs.push_back('{2, 2'd1, 16'hFFFF, 16'h0000, 16'hFFFF, 4'b0100});
    vecs.push_back('{2, 2'd2, 16'h0003, 16'hFFFE, 16'h0002, 4'b1000});
    vecs.push_back('{2, 2'd2, 16'h7FFF, 16'h0001, 16'h8000, 4'b0011});
    vecs.push_back('{2, 2'd3, 16'h0005, 16'h0005, 16'hFFFF, 4'b0100});

    repeat (2) @(posedge clk);
    #1;
    check("reset_result", 32'(res_m), 32'd0);
    check("reset_flags", 32'(flg_m), 32'd0);
    check("reset_valid", 32'(ov_m), 32'd0);
    check("reset_in_ready", 32'(rdy_m), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset while the adder is in its carry step.
    for (int s = 0; s < 3; s++) begin
      sel = s;
      in_valid = 1'b1; op_d = 2'd2; a_d = 16'h0003; b_d = 16'h0001;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      #1;
      check("carry_rst_result", 32'(res_m), 32'd0);
      check("carry_rst_flags", 32'(flg_m), 32'd0);
      check("carry_rst_valid", 32'(ov_m), 32'd0);
      check("carry_rst_in_ready", 32'(rdy_m), 32'd1);
      @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < 4; k++) begin
        @(posedge clk); #1;
        check("post_rst_no_valid", 32'(ov_m), 32'd0);
      end
    end

    // Confirm each unit still works after the mid-operation reset.
    run_vec(vecs[7]);
    run_vec(vecs[15]);
    run_vec(vecs[22]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ones_comp_unit.md
# ones_comp_unit

Parametrised one's-complement arithmetic/compare unit for the AGC simulator datapath. It accepts one operation per transaction over a valid/ready handshake and executes it with a small FSM. ADD/SUB take an extra cycle for the end-around carry, as the AGC adder does. It generalises the earlier fixed 15-bit complement and unsigned-compare checks to any width, a signed one's-complement compare (+0 == −0), and end-around-carry arithmetic with overflow.

## Interface
Parameters:
- WIDTH, 15, word width in bits; MSB is sign.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands/op presented.
- in_ready  output  1  unit can accept; high only in IDLE.
- op  input  2  0=COM, 1=CMP, 2=ADD, 3=SUB.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B (ignored for COM).
- out_valid  output  1  result/flags valid; high only in DONE.
- out_ready  input  1  consumer takes result.
- result  output  WIDTH  registered result.
- gt, eq, lt  output  1 each  registered compare flags.
- ovf  output  1  registered overflow flag (ADD/SUB only).

## Operation
- Accept when in_valid && in_ready; latch op, a, b.
- COM: result = ~a; flags = sign of result vs zero.
- CMP: result = a (passthrough); gt/eq/lt = signed one's-complement compare of a vs b; all-zeros and all-ones both equal zero; ovf=0.
- ADD: sum = a + b in WIDTH+1 bits; carry-out added back into the LSB (end-around).
- SUB: same as ADD with b replaced by ~b.
- ADD/SUB ovf = operand signs equal and final result sign differs. Flags compare the final result against zero. A −0 result gives eq=1 and is not normalised (5−5 = all ones).
- Exactly one of gt/eq/lt is set whenever out_valid=1.
- FSM states and transitions:
  - IDLE → EXEC on accept.
  - EXEC → DONE for COM/CMP.
  - EXEC → CARRY for ADD/SUB. EXEC registers the raw sum and the carry.
  - CARRY → DONE. CARRY adds the carry back in and computes flags/ovf.
  - DONE → IDLE when out_ready.
- result and flags are stable while out_valid is high and out_ready is low.

## Timing
- Reset (asynchronous, any state):
  - state=IDLE.
  - result=0; gt=eq=lt=ovf=0; out_valid=0.
  - in_ready=1; in_ready is combinational from state.
  - An in-flight operation is discarded. No out_valid follows the release of reset.
- Latency from accept edge to out_valid high: COM/CMP 2 edges, ADD/SUB 3 edges.
- No accept in the same cycle as DONE→IDLE. The minimum transaction period is 3 cycles for COM/CMP and 4 for ADD/SUB.
- Input changes while in_ready=0 are ignored.
- The end-around carry cannot produce a second carry.

## Structure
- Package agc_pkg:
  - op enum (OP_COM, OP_CMP, OP_ADD, OP_SUB).
  - AGC_WORD_W=15.
  - FSM state enum (IDLE, EXEC, CARRY, DONE).
- Sub-module ones_comp_cmp: combinational, parametrised WIDTH, outputs gt/eq/lt with ±0 equal. Instantiated twice: a vs b, and result vs zero.
- Top: FSM, operand registers, sum/carry register, output registers.

## Test plan
- COM a=111001011000010 → result=000110100111101, gt=1, out_valid exactly 2 edges after accept.
- CMP a=111001011000010 (−3389), b=000000000000001 → lt=1, gt=0, eq=0. Unsigned compare would say greater.
- CMP a=000000000000000, b=111111111111111 → eq=1; repeat with operands swapped → eq=1.
- ADD a=000000000000011, b=111111111111110 → result=000000000000010, gt=1, ovf=0, latency 3. ADD 011111111111111 + 000000000000001 → result=100000000000000, ovf=1.
- SUB a=b=000000000000101 → result=111111111111111, eq=1. Then hold out_ready=0 for 5 cycles: outputs stable, in_ready=0.
- Assert reset during CARRY → all outputs 0, in_ready=1 immediately, and no out_valid after release. Repeat all cases with WIDTH=8 and WIDTH=16.
